div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle divide sequencer beside the EX stage. It accepts signed or unsigned 32-bit DIV/DIVU operands and runs a radix-2 restoring divide, one quotient bit per cycle.
- It raises a stall request while busy and returns {remainder, quotient} packed for a HI/LO write.
- EX holds start_i and the operands stable until ready_o, then writes hi_o/lo_o from result_o with whilo_o.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH; iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset
signed_div_i  input  1  1 = signed DIV, 0 = DIVU
opdata1_i  input  WIDTH  dividend
opdata2_i  input  WIDTH  divisor
start_i  input  1  request; held high by EX until ready_o seen
annul_i  input  1  cancel (branch-delay/flush); aborts any in-flight divide
result_o  output  2*WIDTH  [63:32] remainder, [31:0] quotient
ready_o  output  1  result valid
stallreq_o  output  1  pipeline stall request (combinational)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Clock port is clk, reset port is rst; reset asserts when rst = 0.
- During reset: state=IDLE, counter=0, result_o=0, ready_o=0, all internal dividend/divisor/remainder registers 0.
- States: IDLE, BYZERO, ON, END.
- IDLE: when start_i=1 and annul_i=0:
  - divisor==0 -> BYZERO.
  - Otherwise -> ON. Latch |opdata1_i| and |opdata2_i| (absolute value only when signed_div_i=1; else raw). Also latch the sign flags and signed_div_i. Clear remainder; counter=0.
  - If start_i=0 or annul_i=1, stay in IDLE.
- BYZERO: next edge -> END with result 0.
- ON: each cycle:
  - Shift {rem, dividend} left 1 and trial-subtract the divisor from the upper WIDTH+1 bits.
  - If nonnegative, keep the difference and set quotient bit to 1; else restore and set it to 0.
  - Increment counter.
  - After the WIDTH-th iteration (counter==WIDTH) -> END and register the corrected result.
- Sign correction (signed only):
  - Quotient is negated when dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
- END: ready_o=1, result_o stable. Stay in END while start_i=1. On start_i=0 -> IDLE, with ready_o=0 and result_o=0 on that edge.
- annul_i=1 in BYZERO or ON: next edge -> IDLE with ready_o=0, result_o=0 and the partial result discarded. annul_i is ignored in END; the result has already been delivered.
- Latency: start accepted at edge E0.
  - Normal divide: ready_o rises after edge E0+WIDTH+1 (E0+33).
  - Divide-by-zero: ready_o rises after edge E0+2.
- stallreq_o = (IDLE & start_i & ~annul_i) | BYZERO | ON. It is 0 in END so EX can consume the result. It is 0 while rst=0.
- Operand changes during ON/BYZERO are ignored because operands are latched in IDLE.
- A new start_i in END without an intervening low is not a new request; EX must drop start_i for at least one cycle.

Test Plan:
- DIVU 100 / 7, start at E0 -> stallreq_o=1 for 33 cycles; ready_o=1 after E0+33; result_o=0x00000002_0000000E; dropping start_i returns to IDLE, ready_o=0.
- DIV -7 (0xFFFFFFF9) / 2 -> result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). DIV 7 / -2 -> 0x00000001_FFFFFFFD.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. DIVU 0xFFFFFFFF / 1 -> 0x00000000_FFFFFFFF.
- Divide by zero, DIVU 5 / 0 -> ready_o=1 after E0+2, result_o=0, stallreq_o low from that cycle.
- Annul: start DIVU 1000/3, assert annul_i at iteration 10 -> next edge IDLE, ready_o never rises, stallreq_o=0. Immediately start DIVU 9/3 -> 0x00000000_00000003 after 33 edges.
- Async reset: drive rst=0 mid-ON between clock edges -> ready_o/result_o/stallreq_o go 0 without a clock edge. Release, then a fresh start completes normally.

Source files
------------

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU beside the EX stage.
// Returns {remainder, quotient} and requests a pipeline stall while it works.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic             neg_quot;
    logic             neg_rem;

    logic [WIDTH-1:0] abs_op1;
    logic [WIDTH-1:0] abs_op2;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] quot_fixed;
    logic [WIDTH-1:0] rem_fixed;
    logic             accept;
    logic             last_iter;

    assign accept    = start_i && !annul_i;
    assign last_iter = (counter == CW'(WIDTH));

    assign abs_op1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign abs_op2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The partial remainder is always below the divisor, so the true difference fits WIDTH bits.
    assign shifted = {rem, dividend[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});
    assign diff    = shifted[WIDTH-1:0] - divisor;

    assign quot_fixed = neg_quot ? -dividend : dividend;
    assign rem_fixed  = neg_rem  ? -rem      : rem;

    assign stallreq_o = rst && (((state == IDLE) && accept) || (state == BYZERO) || (state == ON));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (opdata2_i == '0) ? BYZERO : ON;
                end
            end
            BYZERO: next_state = annul_i ? IDLE : END;
            ON: begin
                if (annul_i) begin
                    next_state = IDLE;
                end else if (last_iter) begin
                    next_state = END;
                end
            end
            END: begin
                if (!start_i) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: operands latched once in IDLE; ready rises one edge after entering END from BYZERO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            counter  <= '0;
            dividend <= '0;
            divisor  <= '0;
            rem      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                    if (accept && (opdata2_i != '0)) begin
                        dividend <= abs_op1;
                        divisor  <= abs_op2;
                        rem      <= '0;
                        counter  <= '0;
                        neg_quot <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem  <= signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
                BYZERO: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
                ON: begin
                    if (annul_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                        counter  <= '0;
                    end else if (last_iter) begin
                        ready_o  <= 1'b1;
                        result_o <= {rem_fixed, quot_fixed};
                    end else begin
                        rem      <= fits ? diff : shifted[WIDTH-1:0];
                        dividend <= {dividend[WIDTH-2:0], fits};
                        counter  <= counter + 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        ready_o  <= 1'b0;
                        result_o <= '0;
                    end else begin
                        ready_o  <= 1'b1;
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide-by-zero,
// annul, and asynchronous reset, each checked against hand-computed values.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic next_edge(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        annul_i      = 1'b0;
        start_i      = 1'b1;
    endtask

    // Start a divide, check the stall window and exact ready latency, leave start_i high in END.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] expected);
        apply_stimulus(sgn, a, b);
        #1;
        check_output({tag, " stall_at_request"}, 64'(stallreq_o), 64'd1);
        next_edge(1);
        next_edge(32);
        check_output({tag, " ready_before_33"}, 64'(ready_o), 64'd0);
        check_output({tag, " stall_before_33"}, 64'(stallreq_o), 64'd1);
        next_edge(1);
        check_output({tag, " ready_at_33"}, 64'(ready_o), 64'd1);
        check_output({tag, " stall_in_end"}, 64'(stallreq_o), 64'd0);
        check_output({tag, " result"}, result_o, expected);
        next_edge(1);
        check_output({tag, " result_held"}, result_o, expected);
    endtask

    task automatic finish_div(input string tag);
        start_i = 1'b0;
        next_edge(1);
        check_output({tag, " ready_cleared"}, 64'(ready_o), 64'd0);
        check_output({tag, " result_cleared"}, result_o, 64'd0);
    endtask

    initial begin
        rst          = 1'b0;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        #12;
        check_output("reset ready", 64'(ready_o), 64'd0);
        check_output("reset result", result_o, 64'd0);
        check_output("reset stall", 64'(stallreq_o), 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        next_edge(2);
        check_output("idle stall", 64'(stallreq_o), 64'd0);
        check_output("idle ready", 64'(ready_o), 64'd0);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);
        finish_div("divu_100_7");
        run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);
        finish_div("div_m7_2");
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);
        finish_div("div_7_m2");
        run_div("div_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003);
        finish_div("div_m7_m2");
        run_div("divu_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC);
        finish_div("divu_fff9_2");
        run_div("div_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        finish_div("div_min_m1");
        run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF);
        finish_div("divu_max_1");

        apply_stimulus(1'b0, 32'd5, 32'd0);
        #1;
        check_output("byzero stall_at_request", 64'(stallreq_o), 64'd1);
        next_edge(1);
        check_output("byzero stall_e0", 64'(stallreq_o), 64'd1);
        check_output("byzero ready_e0", 64'(ready_o), 64'd0);
        next_edge(1);
        check_output("byzero ready_e1", 64'(ready_o), 64'd0);
        check_output("byzero stall_e1", 64'(stallreq_o), 64'd0);
        next_edge(1);
        check_output("byzero ready_e2", 64'(ready_o), 64'd1);
        check_output("byzero result", result_o, 64'd0);
        check_output("byzero stall_e2", 64'(stallreq_o), 64'd0);
        finish_div("byzero");

        apply_stimulus(1'b0, 32'd1000, 32'd3);
        next_edge(1);
        next_edge(10);
        annul_i = 1'b1;
        #1;
        check_output("annul stall_in_on", 64'(stallreq_o), 64'd1);
        next_edge(1);
        check_output("annul ready", 64'(ready_o), 64'd0);
        check_output("annul result", result_o, 64'd0);
        check_output("annul stall", 64'(stallreq_o), 64'd0);
        next_edge(1);
        check_output("annul stays_idle", 64'(ready_o), 64'd0);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);
        finish_div("divu_9_3");

        apply_stimulus(1'b0, 32'd100, 32'd7);
        next_edge(1);
        next_edge(5);
        check_output("async_on stall_before", 64'(stallreq_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check_output("async_on stall", 64'(stallreq_o), 64'd0);
        check_output("async_on ready", 64'(ready_o), 64'd0);
        check_output("async_on result", result_o, 64'd0);
        start_i = 1'b0;
        next_edge(1);
        #2 rst = 1'b1;
        next_edge(1);
        check_output("async_on idle_after", 64'(stallreq_o), 64'd0);
        run_div("after_reset", 1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2);
        #2 rst = 1'b0;
        #1;
        check_output("async_end ready", 64'(ready_o), 64'd0);
        check_output("async_end result", result_o, 64'd0);
        start_i = 1'b0;
        #2 rst = 1'b1;
        next_edge(1);
        check_output("async_end idle", 64'(ready_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
